vx_dispatch_xbar: RTL and testbench

- Parametrised successor to the per-issue-slot dispatcher. Routes decoded-operand packets from NUM_INPUTS issue slots to NUM_UNITS execution-unit types. Each unit type exposes NUM_LANES output lanes.
- Issue slot i maps to lane (i % NUM_LANES) of the unit named by its ex_type field.
- Slots sharing a lane are arbitrated round-robin.
- Each (unit, lane) has a registered elastic buffer.
- Each output packet carries the last active thread id and the source slot index.

---
 rtl/vx_dispatch_pkg.sv | 27 ++
 rtl/vx_dispatch_lane.sv | 81 ++++++++
 rtl/vx_dispatch_xbar.sv | 117 +++++++++++
 tb/tb_vx_dispatch_xbar.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vx_dispatch_pkg.sv
// rtl/vx_dispatch_pkg.sv - shared types, width helpers and constants for the dispatch crossbar
package vx_dispatch_pkg;

    localparam int PERF_W = 44;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pkt_width(input int dataw, input int threads, input int inputs, input int lanes);
        return dataw + threads + clog2_min1(threads) + clog2_min1(inputs / lanes);
    endfunction

    localparam int DEF_DATAW       = 128;
    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_NUM_INPUTS  = 4;
    localparam int DEF_NUM_LANES   = 2;

    // Field order of an output packet, shown at the default configuration
    typedef struct packed {
        logic [DEF_DATAW-1:0]                                       data;
        logic [DEF_NUM_THREADS-1:0]                                 tmask;
        logic [clog2_min1(DEF_NUM_THREADS)-1:0]                     last_tid;
        logic [clog2_min1(DEF_NUM_INPUTS / DEF_NUM_LANES)-1:0]      src;
    } dispatch_pkt_t;

endpackage

// File: rtl/vx_dispatch_lane.sv
// rtl/vx_dispatch_lane.sv - round-robin arbiter feeding one registered elastic buffer
module vx_dispatch_lane
    import vx_dispatch_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int BUF_SIZE = 2,
    parameter int WIDTH    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data
);
    localparam int PW = clog2_min1(NUM_REQ);
    localparam int AW = $clog2(BUF_SIZE);
    localparam int CW = $clog2(BUF_SIZE + 1);

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [WIDTH-1:0] mem [BUF_SIZE];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             not_full;
    logic             push;
    logic             pop;

    // Scan downward so the nearest requester at or after rr_ptr wins last
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // A full buffer still accepts when the head leaves in the same cycle
    assign not_full  = (count != CW'(BUF_SIZE)) || out_ready;
    assign push      = gnt_any && not_full;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    always_comb begin
        ready          = '0;
        ready[gnt_idx] = push;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_data[gnt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= PW'((int'(gnt_idx) + 1) % NUM_REQ);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/vx_dispatch_xbar.sv
// rtl/vx_dispatch_xbar.sv - issue-slot to execution-unit dispatch crossbar; optional DISPATCH_PERF_EN stall counters
module vx_dispatch_xbar
    import vx_dispatch_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_UNITS   = 4,
    parameter int NUM_LANES   = 2,
    parameter int BUF_SIZE    = 2,
    parameter int NUM_THREADS = 4,
    parameter int DATAW       = 128,
    parameter int EX_BITS     = clog2_min1(NUM_UNITS),
    parameter int NT_BITS     = clog2_min1(NUM_THREADS),
    parameter int SRC_BITS    = clog2_min1(NUM_INPUTS / NUM_LANES),
    parameter int OUTW        = pkt_width(DATAW, NUM_THREADS, NUM_INPUTS, NUM_LANES)
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_INPUTS-1:0]                       in_valid,
    output logic [NUM_INPUTS-1:0]                       in_ready,
    input  logic [NUM_INPUTS-1:0][EX_BITS-1:0]          in_ex_type,
    input  logic [NUM_INPUTS-1:0][NUM_THREADS-1:0]      in_tmask,
    input  logic [NUM_INPUTS-1:0][DATAW-1:0]            in_data,
    output logic [NUM_UNITS*NUM_LANES-1:0]              out_valid,
    input  logic [NUM_UNITS*NUM_LANES-1:0]              out_ready,
    output logic [NUM_UNITS*NUM_LANES-1:0][OUTW-1:0]    out_data
`ifdef DISPATCH_PERF_EN
    ,
    output logic [NUM_UNITS-1:0][PERF_W-1:0]            perf_stalls
`endif
);
    localparam int GROUP = NUM_INPUTS / NUM_LANES;

    logic [NUM_INPUTS-1:0][NT_BITS-1:0] last_tid;
    logic [NUM_INPUTS-1:0][OUTW-1:0]    pkt;
    logic [NUM_UNITS-1:0][NUM_INPUTS-1:0] unit_ready;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            last_tid[i] = '0;
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (in_tmask[i][t]) last_tid[i] = NT_BITS'(t);
            end
        end
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_slot
        assign pkt[i] = {in_data[i], in_tmask[i], last_tid[i], SRC_BITS'(i / NUM_LANES)};

        // An out-of-range unit type never matches a lane, so the slot stalls
        a_ex_type_range: assert property (@(posedge clk) disable iff (reset)
            in_valid[i] |-> (int'(in_ex_type[i]) < NUM_UNITS));
    end

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            logic [GROUP-1:0]           req;
            logic [GROUP-1:0]           rdy;
            logic [GROUP-1:0][OUTW-1:0] req_data;

            for (genvar g = 0; g < GROUP; g++) begin : g_member
                assign req[g]      = in_valid[g*NUM_LANES + l] && (in_ex_type[g*NUM_LANES + l] == EX_BITS'(u));
                assign req_data[g] = pkt[g*NUM_LANES + l];
                assign unit_ready[u][g*NUM_LANES + l] = rdy[g];
            end

            vx_dispatch_lane #(
                .NUM_REQ  (GROUP),
                .BUF_SIZE (BUF_SIZE),
                .WIDTH    (OUTW)
            ) u_lane (
                .clk       (clk),
                .reset     (reset),
                .req       (req),
                .req_data  (req_data),
                .ready     (rdy),
                .out_valid (out_valid[u*NUM_LANES + l]),
                .out_ready (out_ready[u*NUM_LANES + l]),
                .out_data  (out_data[u*NUM_LANES + l])
            );
        end
    end

    always_comb begin
        in_ready = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            in_ready = in_ready | unit_ready[u];
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [NUM_UNITS-1:0] stall;
    logic [NUM_UNITS-1:0] stall_q;

    always_comb begin
        stall = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (in_valid[i] && !in_ready[i] && (in_ex_type[i] == EX_BITS'(u))) stall[u] = 1'b1;
            end
        end
    end

    // Stall flag is pipelined one stage ahead of the adders
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q     <= '0;
            perf_stalls <= '0;
        end else begin
            stall_q <= stall;
            for (int u = 0; u < NUM_UNITS; u++) begin
                perf_stalls[u] <= perf_stalls[u] + PERF_W'(stall_q[u]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_dispatch_xbar.sv
// tb/tb_vx_dispatch_xbar.sv - directed self-checking bench for vx_dispatch_xbar
module tb_vx_dispatch_xbar;
    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        in_valid;
    logic [3:0]        in_ready;
    logic [3:0][1:0]   in_ex_type;
    logic [3:0][3:0]   in_tmask;
    logic [3:0][127:0] in_data;
    logic [7:0]        out_valid;
    logic [7:0]        out_ready;
    logic [7:0][134:0] out_data;
`ifdef DISPATCH_PERF_EN
    logic [3:0][43:0]  perf_stalls;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    vx_dispatch_xbar dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ex_type (in_ex_type),
        .in_tmask   (in_tmask),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef DISPATCH_PERF_EN
        ,
        .perf_stalls(perf_stalls)
`endif
    );

    // Output layout: [134:7] data, [6:3] tmask, [2:1] last_tid, [0] src
    function automatic logic [63:0] o_src(input int k);
        return 64'(out_data[k][0]);
    endfunction
    function automatic logic [63:0] o_tid(input int k);
        return 64'(out_data[k][2:1]);
    endfunction
    function automatic logic [63:0] o_tmask(input int k);
        return 64'(out_data[k][6:3]);
    endfunction
    function automatic logic [63:0] o_data(input int k);
        return out_data[k][70:7];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = '0;
        in_ex_type = '0;
        in_tmask   = '0;
        in_data    = '0;
        out_ready  = 8'hFF;
        tick();
        tick();
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        reset = 1'b0;

        // single slot 0 -> unit 2 lane 0 (flat 4)
        in_valid      = 4'b0001;
        in_ex_type[0] = 2'd2;
        in_tmask[0]   = 4'b0110;
        in_data[0]    = {64'hDEAD_BEEF_0000_0000, 64'h1111_2222_3333_4444};
        #1;
        chk("t1_in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = '0;
        chk("t1_out_valid", 64'(out_valid), 64'h10);
        chk("t1_src", o_src(4), 64'd0);
        chk("t1_last_tid", o_tid(4), 64'd2);
        chk("t1_tmask", o_tmask(4), 64'h6);
        chk("t1_data", o_data(4), 64'h1111_2222_3333_4444);
        tick();
        chk("t1_drained", 64'(out_valid), 64'h0);

        // slots 0 and 2 share lane 0 of unit 1 (flat 2): alternate grants
        in_valid      = 4'b0101;
        in_ex_type[0] = 2'd1;
        in_ex_type[2] = 2'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_in_ready", 64'(in_ready), (k % 2 == 0) ? 64'h1 : 64'h4);
            tick();
            chk("t2_out_valid", 64'(out_valid[2]), 64'h1);
            chk("t2_src", o_src(2), 64'(k % 2));
        end
        in_valid = '0;
        tick();
        chk("t2_drained", 64'(out_valid), 64'h0);

        // backpressure on (1,0): two packets fit, then stall, then drain in order
        out_ready[2] = 1'b0;
        in_valid     = 4'b0001;
        in_data[0]   = 128'hA;
        #1;
        chk("t3_rdy_a", 64'(in_ready), 64'h1);
        tick();
        in_data[0] = 128'hB;
        #1;
        chk("t3_rdy_b", 64'(in_ready), 64'h1);
        tick();
        chk("t3_rdy_full", 64'(in_ready), 64'h0);
        chk("t3_head", o_data(2), 64'hA);
        tick();
        chk("t3_still_full", 64'(in_ready), 64'h0);
        in_valid     = '0;
        out_ready[2] = 1'b1;
        #1;
        chk("t3_pop_a", o_data(2), 64'hA);
        tick();
        chk("t3_pop_b_valid", 64'(out_valid[2]), 64'h1);
        chk("t3_pop_b", o_data(2), 64'hB);
        tick();
        chk("t3_empty", 64'(out_valid), 64'h0);

        // slots 0 and 2 target different units: both accepted together
        in_valid      = 4'b0101;
        in_ex_type[0] = 2'd0;
        in_ex_type[2] = 2'd3;
        in_tmask[0]   = 4'b0001;
        in_tmask[2]   = 4'b1111;
        #1;
        chk("t4_in_ready", 64'(in_ready), 64'h5);
        tick();
        in_valid = '0;
        chk("t4_out_valid", 64'(out_valid), 64'h41);
        chk("t4_src_u3", o_src(6), 64'd1);
        chk("t4_tid_u3", o_tid(6), 64'd3);
        chk("t4_src_u0", o_src(0), 64'd0);
        chk("t4_tid_u0", o_tid(0), 64'd0);
        tick();

        // lane 1: tmask 0 and tmask 1000
        in_valid      = 4'b1010;
        in_ex_type[1] = 2'd0;
        in_tmask[1]   = 4'b0000;
        in_ex_type[3] = 2'd2;
        in_tmask[3]   = 4'b1000;
        #1;
        chk("t5_in_ready", 64'(in_ready), 64'hA);
        tick();
        in_valid = '0;
        chk("t5_out_valid", 64'(out_valid), 64'h22);
        chk("t5_tid_zero", o_tid(1), 64'd0);
        chk("t5_tmask_zero", o_tmask(1), 64'h0);
        chk("t5_tid_three", o_tid(5), 64'd3);
        chk("t5_src", o_src(5), 64'd1);
        tick();

        // reset mid-stream discards the buffer and rewinds the pointer
        out_ready[2]  = 1'b0;
        in_valid      = 4'b0001;
        in_ex_type[0] = 2'd1;
        tick();
        in_valid = '0;
        chk("t6_buffered", 64'(out_valid[2]), 64'h1);
        reset = 1'b1;
        tick();
        chk("t6_reset_out_valid", 64'(out_valid), 64'h0);
`ifdef DISPATCH_PERF_EN
        chk("t6_perf_reset", 64'(perf_stalls[1]), 64'h0);
`endif
        reset         = 1'b0;
        out_ready     = 8'hFF;
        in_valid      = 4'b0101;
        in_ex_type[2] = 2'd1;
        #1;
        chk("t6_ptr_rewind", 64'(in_ready), 64'h1);
        tick();
        in_valid = '0;
        tick();
        tick();

`ifdef DISPATCH_PERF_EN
        // unit 3 blocked: 2 accepts then 10 stalled cycles
        out_ready[6]  = 1'b0;
        in_valid      = 4'b0001;
        in_ex_type[0] = 2'd3;
        for (int k = 0; k < 12; k++) tick();
        in_valid = '0;
        tick();
        chk("t7_perf_u3", 64'(perf_stalls[3]), 64'd10);
        out_ready = 8'hFF;
        tick();
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
